// File: rtl/cordic_angle_pkg.sv
// Shared definitions for the CORDIC angle front end.
//   deg_const : whole degrees -> fixed-point constant with frac_w fraction bits
//   Q1..Q4    : quadrant codes presented to the CORDIC core
//   state_t   : range reducer control states
package cordic_angle_pkg;

   localparam logic [2:0] Q1 = 3'd1;
   localparam logic [2:0] Q2 = 3'd2;
   localparam logic [2:0] Q3 = 3'd3;
   localparam logic [2:0] Q4 = 3'd4;

   typedef enum logic [1:0] {IDLE, REDUCE, FOLD, DONE} state_t;

   function automatic int deg_const(input int deg, input int frac_w);
      return deg << frac_w;
   endfunction

endpackage

// File: rtl/quadrant_fold.sv
// Folds a reduced angle r in [0,360) degrees into (-90,90] plus a quadrant code.
// Purely combinational.
//   r        : unsigned reduced angle, FRAC_W fraction bits
//   conv     : signed folded angle
//   quadrant : 1..4
module quadrant_fold
   import cordic_angle_pkg::*;
#(
   parameter int ANGLE_W = 20,
   parameter int FRAC_W  = 4
) (
   input  logic        [ANGLE_W-1:0] r,
   output logic signed [ANGLE_W-1:0] conv,
   output logic        [2:0]         quadrant
);

   localparam logic [ANGLE_W-1:0] C90  = ANGLE_W'(deg_const(90,  FRAC_W));
   localparam logic [ANGLE_W-1:0] C180 = ANGLE_W'(deg_const(180, FRAC_W));
   localparam logic [ANGLE_W-1:0] C270 = ANGLE_W'(deg_const(270, FRAC_W));
   localparam logic [ANGLE_W-1:0] C360 = ANGLE_W'(deg_const(360, FRAC_W));

   // Strict '>' keeps 90/180/270 in the lower quadrant with conv = +90.
   // r - C360 wraps to the correct negative two's-complement value.
   always_comb begin
      conv     = $signed(r);
      quadrant = Q1;
      if (r > C270) begin
         conv     = $signed(r - C360);
         quadrant = Q4;
      end else if (r > C180) begin
         conv     = $signed(r - C180);
         quadrant = Q3;
      end else if (r > C90) begin
         conv     = $signed(r - C90);
         quadrant = Q2;
      end
   end

endmodule

// File: rtl/angle_range_reducer.sv
// Reduces any signed fixed-point angle (degrees) modulo 360 by NSTEP scaled
// subtractions, then folds it into (-90,90] with a quadrant code for CORDIC.
//   clk, rst                    : clock, synchronous active-high reset
//   in_valid/in_ready/in_angle  : input handshake, signed Q(ANGLE_W-FRAC_W).FRAC_W
//   out_valid/out_ready         : result handshake, result held until accepted
//   out_angle_conv/out_quadrant : folded angle and quadrant code 1..4
module angle_range_reducer
   import cordic_angle_pkg::*;
#(
   parameter int ANGLE_W = 20,
   parameter int FRAC_W  = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic        [ANGLE_W-1:0] in_angle,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic signed [ANGLE_W-1:0] out_angle_conv,
   output logic        [2:0]         out_quadrant
);

   localparam int IW    = ANGLE_W - FRAC_W - 1;
   localparam int NSTEP = IW - 8;
   localparam int KW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
   localparam logic [ANGLE_W-1:0] C360 = ANGLE_W'(deg_const(360, FRAC_W));

   if (IW < 9) begin : g_bad_width
      $error("angle_range_reducer: integer width must be at least 9 bits");
   end

   // 360*2^k table. Since |angle| <= 2^(IW+FRAC_W) < 360*2^NSTEP (in LSBs),
   // a restoring division over k = NSTEP-1..0 leaves mag in [0,360).
   logic [ANGLE_W-1:0] step_tab [NSTEP];
   for (genvar i = 0; i < NSTEP; i++) begin : g_step
      assign step_tab[i] = C360 << i;
   end

   state_t                     state, state_n;
   logic        [ANGLE_W-1:0]  mag, mag_n;
   logic                       neg, neg_n;
   logic        [KW-1:0]       k, k_n;
   logic signed [ANGLE_W-1:0]  conv_n;
   logic        [2:0]          quad_n;
   logic                       valid_n;

   logic        [ANGLE_W-1:0]  fold_r;
   logic signed [ANGLE_W-1:0]  fold_conv;
   logic        [2:0]          fold_quad;

   // Negative inputs map to 360 - remainder, except an exact multiple of 360.
   assign fold_r = (neg && (mag != '0)) ? (C360 - mag) : mag;

   quadrant_fold #(.ANGLE_W(ANGLE_W), .FRAC_W(FRAC_W)) u_fold (
      .r        (fold_r),
      .conv     (fold_conv),
      .quadrant (fold_quad)
   );

   assign in_ready = (state == IDLE);

   always_comb begin
      state_n = state;
      mag_n   = mag;
      neg_n   = neg;
      k_n     = k;
      conv_n  = out_angle_conv;
      quad_n  = out_quadrant;
      valid_n = out_valid;
      case (state)
         IDLE: begin
            if (in_valid) begin
               neg_n   = in_angle[ANGLE_W-1];
               // Unsigned magnitude: the most negative input stays representable.
               mag_n   = in_angle[ANGLE_W-1] ? (ANGLE_W'(0) - in_angle) : in_angle;
               k_n     = KW'(NSTEP - 1);
               state_n = REDUCE;
            end
         end
         REDUCE: begin
            if (mag >= step_tab[k])
               mag_n = mag - step_tab[k];
            if (k == '0)
               state_n = FOLD;
            else
               k_n = k - 1'b1;
         end
         FOLD: begin
            conv_n  = fold_conv;
            quad_n  = fold_quad;
            valid_n = 1'b1;
            state_n = DONE;
         end
         DONE: begin
            if (out_ready) begin
               valid_n = 1'b0;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         mag            <= '0;
         neg            <= 1'b0;
         k              <= '0;
         out_angle_conv <= '0;
         out_quadrant   <= Q1;
         out_valid      <= 1'b0;
      end else begin
         state          <= state_n;
         mag            <= mag_n;
         neg            <= neg_n;
         k              <= k_n;
         out_angle_conv <= conv_n;
         out_quadrant   <= quad_n;
         out_valid      <= valid_n;
      end
   end

endmodule

// File: tb/tb_angle_range_reducer.sv
// Directed bench for angle_range_reducer at default parameters (Q15.4,
// value = degrees*16). Inputs are driven and outputs sampled on the falling edge.
module tb_angle_range_reducer;

   localparam int ANGLE_W = 20;
   localparam int NSTEP   = 7;

   logic                      clk = 1'b0;
   logic                      rst;
   logic                      in_valid;
   logic                      in_ready;
   logic        [ANGLE_W-1:0] in_angle;
   logic                      out_valid;
   logic                      out_ready;
   logic signed [ANGLE_W-1:0] out_angle_conv;
   logic        [2:0]         out_quadrant;

   int checks = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   angle_range_reducer #(.ANGLE_W(ANGLE_W), .FRAC_W(4)) dut (
      .clk            (clk),
      .rst            (rst),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_angle       (in_angle),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_angle_conv (out_angle_conv),
      .out_quadrant   (out_quadrant)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, $signed(got), got,
                $signed(exp), exp);
      end
   endtask

   function automatic logic [31:0] sx(input logic signed [ANGLE_W-1:0] v);
      return 32'(v);
   endfunction

   // Send one angle, check latency and result, optionally hold off out_ready
   // for 'hold' cycles while offering another angle, then hand the result off.
   task automatic run(input string tag, input int ang, input int exp_conv,
                      input int exp_q, input int hold);
      int lat;
      @(negedge clk);
      chk({tag, ".in_ready_before"}, 32'(in_ready), 32'd1);
      in_angle = ANGLE_W'(ang);
      in_valid = 1'b1;
      @(negedge clk);                 // accept edge has passed: edge count 1
      in_valid = 1'b0;
      in_angle = 20'h5A5A5;           // must be ignored after acceptance
      chk({tag, ".in_ready_busy"}, 32'(in_ready), 32'd0);
      lat = 1;
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      // out_valid appears after edge NSTEP+2, counting the accept edge as edge 1
      chk({tag, ".latency"}, 32'(lat), 32'(NSTEP + 2));
      chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
      chk({tag, ".conv"}, sx(out_angle_conv), 32'(exp_conv));
      chk({tag, ".quadrant"}, 32'(out_quadrant), 32'(exp_q));
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1;
         in_angle = 20'd1600;
         @(negedge clk);
         chk({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
         chk({tag, ".hold_in_ready"}, 32'(in_ready), 32'd0);
         chk({tag, ".hold_conv"}, sx(out_angle_conv), 32'(exp_conv));
         chk({tag, ".hold_quad"}, 32'(out_quadrant), 32'(exp_q));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, ".valid_drop"}, 32'(out_valid), 32'd0);
      chk({tag, ".in_ready_after"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_angle  = '0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("reset.in_ready", 32'(in_ready), 32'd1);
      chk("reset.out_valid", 32'(out_valid), 32'd0);
      chk("reset.conv", sx(out_angle_conv), 32'd0);
      chk("reset.quadrant", 32'(out_quadrant), 32'd1);

      run("a450",   7200,   1440, 1, 0);
      run("am30",   -480,   -480, 4, 0);
      run("a200p5", 3208,   328,  3, 0);
      run("a180",   2880,   1440, 2, 0);
      run("am2048", -32768, 352,  2, 0);
      run("am360",  -5760,  0,    1, 0);
      run("a0",     0,      0,    1, 0);
      run("a270",   4320,   1440, 3, 0);
      run("am90",   -1440,  1440, 3, 0);
      run("a91",    1456,   16,   2, 0);
      run("a90",    1440,   1440, 1, 0);
      run("bp",     7200,   1440, 1, 5);

      // Reset while reducing abandons the transaction without output.
      @(negedge clk);
      in_angle = 20'd3208;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst.in_ready", 32'(in_ready), 32'd1);
      chk("midrst.out_valid", 32'(out_valid), 32'd0);
      chk("midrst.conv", sx(out_angle_conv), 32'd0);
      repeat (NSTEP + 3) @(negedge clk);
      chk("midrst.no_output", 32'(out_valid), 32'd0);
      run("a360", 5760, 0, 1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
